// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C subordinate front end.
package i2c_pkg;

  localparam int BITS_PER_BYTE = 8;
  localparam logic [3:0] ACK_SLOT = 4'd8;
  localparam logic [3:0] LAST_BIT = 4'(BITS_PER_BYTE - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDRESS,
    ADDR_ACK,
    WRITE_DATA,
    WRITE_ACK,
    READ_DATA,
    READ_ACK,
    WAIT_STOP
  } i2c_seq_state_t;

endpackage

// File: rtl/i2c_frame_sequencer_if.sv
// Bus-side and checker-side signals of the I2C frame sequencer.
interface i2c_frame_sequencer_if;
  logic       scl_in;
  logic       sda_in;
  logic       address_match;
  logic       read_bit;
  logic       start;
  logic       stop;
  logic       scl_rise;
  logic       read_address;
  logic [3:0] clock_count;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       master_nack;

  modport slave (
    input  scl_in, sda_in,
    input  address_match, read_bit,
    output start, stop, scl_rise,
    output read_address, clock_count,
    output sda_oe, rx_data, rx_valid,
    output master_nack
  );

  modport master (
    output scl_in, sda_in,
    output address_match, read_bit,
    input  start, stop, scl_rise,
    input  read_address, clock_count,
    input  sda_oe, rx_data, rx_valid,
    input  master_nack
  );
endinterface

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer with combinational rise/fall strobes.
module i2c_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync;
  logic                   q_d;

  // Reset to the idle bus level so release never looks like an edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync <= '1;
      q_d  <= 1'b1;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], d};
      q_d  <= sync[SYNC_STAGES-1];
    end
  end

  assign q    = sync[SYNC_STAGES-1];
  assign rise = q & ~q_d;
  assign fall = ~q & q_d;

endmodule

// File: rtl/i2c_frame_sequencer.sv
// START/STOP detect, bit counting and address/ACK/data phasing.
module i2c_frame_sequencer
  import i2c_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input logic clk,
  input logic rst_n,
  i2c_frame_sequencer_if.slave bus
);

  logic scl_s, scl_r, scl_f;
  logic sda_s, sda_r, sda_f;

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.scl_in),
    .q    (scl_s),
    .rise (scl_r),
    .fall (scl_f)
  );

  i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (bus.sda_in),
    .q    (sda_s),
    .rise (sda_r),
    .fall (sda_f)
  );

  i2c_seq_state_t state;
  logic           bit_seen;
  logic           rd_q;
  logic [7:0]     shift;
  logic [3:0]     cnt_nxt;
  logic           is_start, is_stop, active, adv;

  assign is_start = sda_f & scl_s;
  assign is_stop  = sda_r & scl_s;
  assign active   = (state != IDLE) && (state != WAIT_STOP);
  assign adv      = scl_f & bit_seen;
  assign cnt_nxt  = (bus.clock_count == ACK_SLOT) ?
                    4'd0 : bus.clock_count + 4'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= IDLE;
      bit_seen         <= 1'b0;
      rd_q             <= 1'b0;
      shift            <= '0;
      bus.start        <= 1'b0;
      bus.stop         <= 1'b0;
      bus.scl_rise     <= 1'b0;
      bus.read_address <= 1'b0;
      bus.clock_count  <= '0;
      bus.sda_oe       <= 1'b0;
      bus.rx_data      <= '0;
      bus.rx_valid     <= 1'b0;
      bus.master_nack  <= 1'b0;
    end else begin
      bus.start       <= 1'b0;
      bus.stop        <= 1'b0;
      bus.rx_valid    <= 1'b0;
      bus.master_nack <= 1'b0;
      bus.scl_rise    <= scl_r;
      if (is_start) begin
        state            <= ADDRESS;
        bus.start        <= 1'b1;
        bus.clock_count  <= '0;
        bus.sda_oe       <= 1'b0;
        bus.read_address <= 1'b1;
        bit_seen         <= 1'b0;
        shift            <= '0;
      end else if (is_stop) begin
        state            <= IDLE;
        bus.stop         <= 1'b1;
        bus.clock_count  <= '0;
        bus.sda_oe       <= 1'b0;
        bus.read_address <= 1'b0;
        bit_seen         <= 1'b0;
      end else if (active && scl_r) begin
        bit_seen <= 1'b1;
        if (state == WRITE_DATA)
          shift <= {shift[6:0], sda_s};
        if (state == READ_ACK && sda_s) begin
          bus.master_nack <= 1'b1;
          state           <= WAIT_STOP;
        end
      end else if (active && adv) begin
        bit_seen        <= 1'b0;
        bus.clock_count <= cnt_nxt;
        unique case (state)
          ADDRESS: if (bus.clock_count == LAST_BIT) begin
            bus.read_address <= 1'b0;
            rd_q             <= bus.read_bit;
            if (bus.address_match) begin
              state      <= ADDR_ACK;
              bus.sda_oe <= 1'b1;
            end else begin
              state           <= IDLE;
              bus.clock_count <= '0;
            end
          end
          ADDR_ACK: if (bus.clock_count == ACK_SLOT) begin
            bus.sda_oe <= 1'b0;
            state      <= rd_q ? READ_DATA : WRITE_DATA;
          end
          WRITE_DATA: if (bus.clock_count == LAST_BIT) begin
            bus.rx_data  <= shift;
            bus.rx_valid <= 1'b1;
            bus.sda_oe   <= 1'b1;
            state        <= WRITE_ACK;
          end
          WRITE_ACK: if (bus.clock_count == ACK_SLOT) begin
            bus.sda_oe <= 1'b0;
            state      <= WRITE_DATA;
          end
          READ_DATA: if (bus.clock_count == LAST_BIT)
            state <= READ_ACK;
          READ_ACK: if (bus.clock_count == ACK_SLOT)
            state <= READ_DATA;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_frame_sequencer.sv
// Bench for i2c_frame_sequencer: protocol-level model plus literals.
module tb_i2c_frame_sequencer;

  typedef struct packed {
    logic       st, sp, sr, rv, nk, ra, oe;
    logic [3:0] cnt;
    logic [7:0] rx;
  } exp_t;

  typedef enum {
    M_IDLE, M_ADDR, M_AACK, M_WR, M_WACK, M_RD, M_RACK, M_WAIT
  } mphase_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  i2c_frame_sequencer_if bus ();

  i2c_frame_sequencer #(.SYNC_STAGES(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  exp_t cur, d1, d2, d3;

  always @(posedge clk) begin
    if (!rst_n) begin
      d1 <= '0;
      d2 <= '0;
      d3 <= '0;
    end else begin
      d1 <= cur;
      d2 <= d1;
      d3 <= d2;
    end
  end

  mphase_t    m_ph;
  int         m_bit;
  logic       m_seen, m_rd, pscl, psda;
  logic [7:0] m_sh;

  int errors = 0;
  int checks = 0;
  int oe_cyc = 0, ra_cyc = 0;
  int nack_n = 0, start_n = 0, stop_n = 0;
  logic [7:0] rx_q[$];

  initial begin
    #5000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic chk1(input string n, input logic g, input logic e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%b exp=%b t=%0t", n, g, e, $time);
    end
  endtask

  task automatic chkv(input string n, input logic [31:0] g,
                      input logic [31:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", n, g, e, $time);
    end
  endtask

  task automatic mdl_reset();
    cur    = '0;
    m_ph   = M_IDLE;
    m_bit  = 0;
    m_seen = 1'b0;
    m_rd   = 1'b0;
    m_sh   = '0;
    pscl   = 1'b1;
    psda   = 1'b1;
  endtask

  // Interpret one raw line change as an I2C bus event
  task automatic mdl_ev(input logic c, input logic d);
    bit act;
    act = (m_ph != M_IDLE) && (m_ph != M_WAIT);
    if (pscl && c && psda && !d) begin
      cur.st = 1'b1; m_ph = M_ADDR; m_bit = 0;
      m_seen = 1'b0; cur.oe = 1'b0; cur.ra = 1'b1; m_sh = '0;
    end else if (pscl && c && !psda && d) begin
      cur.sp = 1'b1; m_ph = M_IDLE; m_bit = 0;
      m_seen = 1'b0; cur.oe = 1'b0; cur.ra = 1'b0;
    end else if (!pscl && c) begin
      cur.sr = 1'b1;
      if (act) begin
        m_seen = 1'b1;
        if (m_ph == M_WR) m_sh = 8'((m_sh * 2) + d);
        if (m_ph == M_RACK && d) begin
          cur.nk = 1'b1; m_ph = M_WAIT;
        end
      end
    end else if (pscl && !c && act && m_seen) begin
      m_seen = 1'b0;
      if (m_bit == 7) begin
        m_bit = 8;
        case (m_ph)
          M_ADDR: begin
            cur.ra = 1'b0;
            m_rd = bus.read_bit;
            if (bus.address_match) begin
              m_ph = M_AACK; cur.oe = 1'b1;
            end else begin
              m_ph = M_IDLE; m_bit = 0;
            end
          end
          M_WR: begin
            cur.rx = m_sh; cur.rv = 1'b1;
            cur.oe = 1'b1; m_ph = M_WACK;
          end
          M_RD: m_ph = M_RACK;
          default: ;
        endcase
      end else if (m_bit == 8) begin
        m_bit = 0;
        cur.oe = 1'b0;
        if (m_ph == M_AACK) m_ph = m_rd ? M_RD : M_WR;
        else if (m_ph == M_WACK) m_ph = M_WR;
        else if (m_ph == M_RACK) m_ph = M_RD;
      end else begin
        m_bit++;
      end
    end
    cur.cnt = 4'(m_bit);
    pscl = c;
    psda = d;
  endtask

  task automatic drive(input logic c, input logic d);
    mdl_ev(c, d);
    bus.scl_in = c;
    bus.sda_in = d;
    @(posedge clk); #1;
    cur.st = 1'b0; cur.sp = 1'b0; cur.sr = 1'b0;
    cur.rv = 1'b0; cur.nk = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic bit_(input logic d);
    drive(1'b0, d);
    drive(1'b1, d);
    drive(1'b0, d);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bit_(b[i]);
  endtask

  task automatic do_start();
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic do_stop();
    drive(1'b0, 1'b0);
    drive(1'b1, 1'b0);
    drive(1'b1, 1'b1);
  endtask

  task automatic do_rstart();
    drive(1'b0, 1'b1);
    drive(1'b1, 1'b1);
    drive(1'b1, 1'b0);
    drive(1'b0, 1'b0);
  endtask

  task automatic cmp_cycle();
    chk1("start", bus.start, d3.st);
    chk1("stop", bus.stop, d3.sp);
    chk1("scl_rise", bus.scl_rise, d3.sr);
    chk1("rx_valid", bus.rx_valid, d3.rv);
    chk1("master_nack", bus.master_nack, d3.nk);
    chk1("read_address", bus.read_address, d3.ra);
    chk1("sda_oe", bus.sda_oe, d3.oe);
    chkv("clock_count", 32'(bus.clock_count), 32'(d3.cnt));
    chkv("rx_data", 32'(bus.rx_data), 32'(d3.rx));
    if (bus.sda_oe) oe_cyc++;
    if (bus.read_address) ra_cyc++;
    if (bus.rx_valid) rx_q.push_back(bus.rx_data);
    if (bus.master_nack) nack_n++;
    if (bus.start) start_n++;
    if (bus.stop) stop_n++;
  endtask

  int s_oe, s_ra, s_rx, s_nk, s_st, s_sp;

  task automatic snap();
    s_oe = oe_cyc; s_ra = ra_cyc; s_rx = rx_q.size();
    s_nk = nack_n; s_st = start_n; s_sp = stop_n;
  endtask

  initial begin
    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    bus.address_match = 1'b0;
    bus.read_bit = 1'b0;
    mdl_reset();
    fork
      forever begin
        @(negedge clk);
        cmp_cycle();
      end
    join_none
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk1("rst_sda_oe", bus.sda_oe, 1'b0);
    chkv("rst_count", 32'(bus.clock_count), 32'd0);
    chkv("rst_rx_data", 32'(bus.rx_data), 32'd0);

    // matched write: 0x66+W, 0xA5, 0x3C, STOP
    snap();
    bus.address_match = 1'b1;
    bus.read_bit = 1'b0;
    do_start();
    send_byte(8'hCC);
    bit_(1'b1);
    chkv("wr_ra_cycles", 32'(ra_cyc - s_ra), 32'd100);
    chkv("wr_addr_ack_cycles", 32'(oe_cyc - s_oe), 32'd12);
    send_byte(8'hA5);
    bit_(1'b1);
    send_byte(8'h3C);
    bit_(1'b1);
    do_stop();
    chkv("wr_rx_count", 32'(rx_q.size() - s_rx), 32'd2);
    if (rx_q.size() >= s_rx + 2) begin
      chkv("wr_rx0", 32'(rx_q[s_rx]), 32'hA5);
      chkv("wr_rx1", 32'(rx_q[s_rx + 1]), 32'h3C);
    end
    chkv("wr_ack_cycles", 32'(oe_cyc - s_oe), 32'd36);
    chkv("wr_stop_pulses", 32'(stop_n - s_sp), 32'd1);
    chkv("wr_state", 32'(dut.state), 32'(i2c_pkg::IDLE));

    // unmatched address 0x55 then a data byte
    snap();
    bus.address_match = 1'b0;
    do_start();
    send_byte(8'hAA);
    bit_(1'b1);
    send_byte(8'hA5);
    bit_(1'b1);
    do_stop();
    chkv("nm_ack_cycles", 32'(oe_cyc - s_oe), 32'd0);
    chkv("nm_rx_count", 32'(rx_q.size() - s_rx), 32'd0);
    chkv("nm_ra_cycles", 32'(ra_cyc - s_ra), 32'd100);

    // read: master ACKs byte 1, NACKs byte 2
    snap();
    bus.address_match = 1'b1;
    bus.read_bit = 1'b1;
    do_start();
    send_byte(8'hCD);
    bit_(1'b1);
    send_byte(8'hFF);
    bit_(1'b0);
    send_byte(8'hFF);
    bit_(1'b1);
    chkv("rd_nack_pulses", 32'(nack_n - s_nk), 32'd1);
    chkv("rd_state", 32'(dut.state), 32'(i2c_pkg::WAIT_STOP));
    chkv("rd_count", 32'(bus.clock_count), 32'd8);
    chkv("rd_ack_cycles", 32'(oe_cyc - s_oe), 32'd12);
    chkv("rd_rx_count", 32'(rx_q.size() - s_rx), 32'd0);
    do_stop();
    chkv("rd_state_end", 32'(dut.state), 32'(i2c_pkg::IDLE));

    // repeated START after bit 3 of a write byte
    bus.read_bit = 1'b0;
    do_start();
    send_byte(8'hCC);
    bit_(1'b1);
    bit_(1'b1);
    bit_(1'b0);
    bit_(1'b1);
    bit_(1'b1);
    snap();
    do_rstart();
    chkv("rs_start_pulses", 32'(start_n - s_st), 32'd1);
    chkv("rs_count", 32'(bus.clock_count), 32'd0);
    chk1("rs_read_address", bus.read_address, 1'b1);
    chkv("rs_state", 32'(dut.state), 32'(i2c_pkg::ADDRESS));
    chkv("rs_rx_count", 32'(rx_q.size() - s_rx), 32'd0);
    do_stop();

    // reset while the address ACK is being driven
    do_start();
    send_byte(8'hCC);
    drive(1'b0, 1'b1);
    chk1("pre_rst_sda_oe", bus.sda_oe, 1'b1);
    chkv("pre_rst_state", 32'(dut.state), 32'(i2c_pkg::ADDR_ACK));
    rst_n = 1'b0;
    mdl_reset();
    @(posedge clk); #1;
    chk1("mid_rst_sda_oe", bus.sda_oe, 1'b0);
    chkv("mid_rst_count", 32'(bus.clock_count), 32'd0);
    chkv("mid_rst_state", 32'(dut.state), 32'(i2c_pkg::IDLE));
    bus.scl_in = 1'b1;
    bus.sda_in = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/i2c_frame_sequencer.md
# i2c_frame_sequencer

Oversampling front end of the I2C subordinate: synchronizes raw SCL/SDA into the system clock domain, detects START/STOP, tracks the bit index within each byte and sequences address, ACK and data phases. Feeds `start`, `stop`, `read_address` and `clock_count` to the address checker stage downstream. Consumes `address_match` and `read_bit` back from that stage. Drives the ACK pull-down and delivers received write bytes.

## Interface
- `SYNC_STAGES`, 2, synchronizer flops on `scl_in`/`sda_in` (≥2)
- `clk`  in  1  system clock; must be ≥ 8× SCL frequency
- `rst_n`  in  1  reset, synchronous, active-low
- `scl_in`  in  1  raw bus SCL
- `sda_in`  in  1  raw bus SDA
- `address_match`  in  1  from address checker; valid while `read_address` and `clock_count`==7
- `read_bit`  in  1  from address checker; 1 = master read
- `start`  out  1  one-`clk` pulse on START or repeated START
- `stop`  out  1  one-`clk` pulse on STOP
- `scl_rise`  out  1  one-`clk` pulse per synchronized SCL rising edge
- `read_address`  out  1  high during address byte bits 0..7
- `clock_count`  out  4  bit index in current byte: 0..7 data, 8 = ACK slot
- `sda_oe`  out  1  1 = pull SDA low (ACK)
- `rx_data`  out  8  last received write byte, MSB first
- `rx_valid`  out  1  one-`clk` pulse when `rx_data` updates
- `master_nack`  out  1  one-`clk` pulse when master NACKs a read byte

## Operation
- Synchronized `scl_s`/`sda_s`, one registered copy each for edge detection.
- START: `sda_s` falls while `scl_s` high. STOP: `sda_s` rises while `scl_s` high. Both are checked in every state and take priority over bit handling in the same cycle.
- States: IDLE, ADDRESS, ADDR_ACK, WRITE_DATA, WRITE_ACK, READ_DATA, READ_ACK, WAIT_STOP.
- START (any state) -> ADDRESS, `clock_count`=0, `sda_oe`=0, `bit_seen`=0.
- STOP (any state) -> IDLE, `sda_oe`=0.
- Bit sampling on `scl_rise`; sets `bit_seen`.
- `clock_count` advances on SCL fall only if `bit_seen`, then clears `bit_seen`. The first fall after START therefore does not count. Count wraps 8 -> 0.
- ADDRESS: `read_address`=1.
  - On the fall ending bit 7 (7 -> 8), register `address_match`/`read_bit`.
  - Match -> ADDR_ACK with `sda_oe`=1. No match -> IDLE; bus is ignored until next START.
- ADDR_ACK: on the fall ending the ACK slot, `sda_oe`=0. Go to READ_DATA if the registered `read_bit`=1, else WRITE_DATA.
- WRITE_DATA: shift `sda_s` into an 8-bit shift register on each `scl_rise` (count 0..7). On the fall 7 -> 8: update `rx_data`, pulse `rx_valid`, set `sda_oe`=1, go to WRITE_ACK.
- WRITE_ACK: on the fall 8 -> 0, `sda_oe`=0, go to WRITE_DATA.
- READ_DATA: `sda_oe`=0; byte transmit is owned by a separate stage. On the fall 7 -> 8, go to READ_ACK.
- READ_ACK: on `scl_rise`, sample `sda_s`.
  - 1: pulse `master_nack`, go to WAIT_STOP.
  - 0: on fall go to READ_DATA.
- WAIT_STOP: only START/STOP are acted on.
- Undefined state encodings -> IDLE.

## Timing
- Reset values: all outputs 0, state IDLE, shift register 0, `bit_seen` 0. `sda_oe` is released on the first `clk` edge with `rst_n` low, including mid-transfer.
- Bus-to-pulse latency: `start`/`stop`/`scl_rise` assert exactly `SYNC_STAGES`+1 `clk` after the raw edge.
- `clock_count`, `read_address` and `sda_oe` change in the cycle after the detected SCL fall. They are stable throughout SCL high.
- `rx_valid`/`master_nack` are single-cycle, registered, and never asserted in the same cycle.
- Repeated START mid-byte discards the partial byte; no `rx_valid` is issued.
- The ACK pull-down is asserted only while SCL is low. If SCL is seen high during the ACK slot, this does not release it.

## Structure
- `i2c_pkg`:
  - state enum `i2c_seq_state_t`
  - `BITS_PER_BYTE`=8
  - `ACK_SLOT`=4'd8
- Sub-module `i2c_sync_edge`: `SYNC_STAGES`-flop synchronizer plus rise/fall pulse outputs. Instantiated for SCL and SDA.

## Test plan
- Reset mid-ADDR_ACK with `sda_oe`=1: drive `rst_n`=0 -> next `clk`: `sda_oe`=0, state IDLE, `clock_count`=0.
- START, address 0x66 + W, `address_match`=1 -> `read_address` high for 8 bits, `sda_oe`=1 for exactly the 9th SCL low+high, then WRITE_DATA.
- Same with address 0x55, `address_match`=0 -> `sda_oe` never asserts. Following byte 0xA5 gives no `rx_valid`.
- Write 0x66+W, then 0xA5, 0x3C -> `rx_valid` twice, `rx_data`=0xA5 then 0x3C, ACK after each. STOP -> `stop` pulse, IDLE.
- 0x66+R, master ACKs byte 1 and NACKs byte 2 -> one `master_nack` after the 2nd byte's 9th `scl_rise`, WAIT_STOP.
- Repeated START after bit 3 of a write byte -> `start` pulse, `clock_count`=0, ADDRESS, no `rx_valid`.
